mem_store_writer: RTL

- Write-side counterpart to the memory fetch path: accepts a burst of 16-bit machine-code words over a valid/ready handshake and writes each one into the 16-word instruction memory.
- Writes go through a single-cycle write strobe, with auto-incrementing addresses starting at a base address.
- Optional verify pass re-reads the stored words and compares a running 16-bit checksum.
- Sits between the translator output stream and the memory write port; the fetch logic later reads what this block stores.

---
 rtl/mem_store_writer_pkg.sv | 25 ++
 rtl/mem_store_writer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mem_store_writer_pkg.sv
// Shared definitions for the instruction-memory store writer.
//   AW/DW/DEPTH/CW : default address width, word width, memory depth, burst count width
//   state_t        : controller states
//   csum_add       : running checksum accumulate, mod 2^DW
package mem_store_writer_pkg;

    localparam int AW    = 12;
    localparam int DW    = 16;
    localparam int DEPTH = 16;
    localparam int CW    = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_WRITE,
        S_VREAD,
        S_VDRAIN,
        S_FINISH
    } state_t;

    function automatic logic [DW-1:0] csum_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/mem_store_writer.sv
// Instruction memory store writer.
// Accepts a burst of machine-code words over a valid/ready handshake and
// writes each into the instruction memory with auto-incrementing addresses
// from a base. An optional verify pass reads the burst back and compares the
// readback sum against the checksum of the words written.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start                 one-cycle burst request (IDLE only)
//   verify, base_addr,    burst parameters, sampled with start
//   count
//   in_valid/in_ready/    word input stream
//   in_data
//   mem_we, mem_re,       memory port: one-cycle write / read strobes
//   mem_addr, mem_wdata,
//   mem_rdata             read data, valid one cycle after mem_re
//   busy, done            busy from the cycle after start; done one-cycle pulse
//   err                   range or verify failure, held until next start
//   checksum              mod-2^DW sum of the words written in the last burst
module mem_store_writer
    import mem_store_writer_pkg::*;
#(
    parameter int AW    = 12,
    parameter int DW    = 16,
    parameter int DEPTH = 16,
    parameter int CW    = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          verify,
    input  logic [AW-1:0] base_addr,
    input  logic [CW-1:0] count,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          mem_we,
    output logic          mem_re,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [DW-1:0] checksum
);

    localparam logic [AW:0] DEPTH_X = (AW+1)'(DEPTH);

    // End of burst is checked one bit wider than the address bus so that a
    // base near the top of the address space cannot wrap into range. Since
    // base >= 0, this also rejects any count larger than DEPTH.
    function automatic logic range_bad(input logic [AW-1:0] b, input logic [CW-1:0] c);
        logic [AW:0] last;
        last = {1'b0, b} + (AW+1)'(c);
        return last > DEPTH_X;
    endfunction

    state_t        state, state_nxt;

    logic [AW-1:0] base_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] idx_q;      // next write slot
    logic [CW-1:0] vidx_q;     // next readback slot
    logic          verify_q;
    logic [DW-1:0] word_q;     // word captured in ACCEPT, written in WRITE
    logic [DW-1:0] csum_q;
    logic [DW-1:0] rsum_q;
    logic          err_q;
    logic          rd_pend_q;  // mem_rdata carries a verify word this cycle

    logic          last_wr;
    logic          last_rd;

    assign last_wr = (idx_q + CW'(1)) == cnt_q;
    assign last_rd = (vidx_q + CW'(1)) == cnt_q;

    // ---------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // ---------------------------------------------------------------
    // Next state and outputs. Strobes decode straight from the state so
    // an async reset drops mem_we/mem_re immediately.
    // ---------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        done      = 1'b0;
        busy      = (state != S_IDLE);

        case (state)
            S_IDLE: begin
                if (start) begin
                    if (count == '0)                    state_nxt = S_FINISH;
                    else if (range_bad(base_addr, count)) state_nxt = S_FINISH;
                    else                                state_nxt = S_ACCEPT;
                end
            end
            S_ACCEPT: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = S_WRITE;
            end
            S_WRITE: begin
                mem_we    = 1'b1;
                mem_addr  = base_q + AW'(idx_q);
                mem_wdata = word_q;
                if (last_wr) state_nxt = verify_q ? S_VREAD : S_FINISH;
                else         state_nxt = S_ACCEPT;
            end
            S_VREAD: begin
                mem_re   = 1'b1;
                mem_addr = base_q + AW'(vidx_q);
                if (last_rd) state_nxt = S_VDRAIN;
            end
            S_VDRAIN: begin
                state_nxt = S_FINISH;
            end
            S_FINISH: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Datapath
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q    <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            vidx_q    <= '0;
            verify_q  <= 1'b0;
            word_q    <= '0;
            csum_q    <= '0;
            rsum_q    <= '0;
            err_q     <= 1'b0;
            rd_pend_q <= 1'b0;
        end else begin
            rd_pend_q <= (state == S_VREAD);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        base_q   <= base_addr;
                        cnt_q    <= count;
                        verify_q <= verify;
                        csum_q   <= '0;
                        idx_q    <= '0;
                        // An empty burst is never a range error.
                        err_q    <= (count != '0) && range_bad(base_addr, count);
                    end
                end
                S_ACCEPT: begin
                    if (in_valid) begin
                        word_q <= in_data;
                        csum_q <= csum_add(csum_q, in_data);
                    end
                end
                S_WRITE: begin
                    idx_q  <= idx_q + CW'(1);
                    vidx_q <= '0;
                    rsum_q <= '0;
                end
                S_VREAD: begin
                    vidx_q <= vidx_q + CW'(1);
                    if (rd_pend_q) rsum_q <= csum_add(rsum_q, mem_rdata);
                end
                S_VDRAIN: begin
                    // Last readback word arrives this cycle; fold it in
                    // combinationally for the compare.
                    if (csum_add(rsum_q, mem_rdata) != csum_q) err_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign err      = err_q;
    assign checksum = csum_q;

endmodule
